multi_clock_divider: RTL and testbench

Parametrised multi-channel clock divider for the board-clock domain. Generates NUM_CH independent divided square outputs and matching single-cycle ticks. Each channel has a runtime-programmable divisor, a level enable and a synchronous restart. Sits at the top of each game design, feeding game-step, display-refresh and blink timing logic in place of fixed-ratio dividers.

---
 rtl/multi_clock_divider.sv | 103 ++++++++++
 tb/tb_multi_clock_divider.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_clock_divider.sv
// Multi-channel programmable clock divider: per-channel square output and
// one-cycle tick, with runtime divisor writes that only land on period boundaries.

module multi_clock_divider_ch #(
    parameter int               CNT_W = 32,
    parameter logic [CNT_W-1:0] INIT  = CNT_W'(2)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             restart,
    input  logic             wr_hit,
    input  logic [CNT_W-1:0] wr_div,
    output logic             clk_out,
    output logic             tick
);
    localparam logic [CNT_W-1:0] TWO    = CNT_W'(2);
    localparam logic [CNT_W-1:0] INIT_C = (INIT < TWO) ? TWO : INIT;

    logic [CNT_W-1:0] act, pend, cnt;
    logic             pf;

    logic [CNT_W-1:0] new_div, src_div;
    logic [CNT_W-1:0] nxt_act, nxt_pend, nxt_cnt;
    logic             nxt_pf, nxt_clk, nxt_tick;
    logic             wrap, boundary;

    always_comb begin
        new_div  = (wr_div < TWO) ? TWO : wr_div;
        // A write landing on the same edge as a boundary is promoted directly.
        src_div  = wr_hit ? new_div : pend;
        wrap     = (cnt == act - CNT_W'(1));
        boundary = restart || !en || wrap;

        nxt_pend = src_div;
        nxt_pf   = pf || wr_hit;
        nxt_act  = act;
        if (boundary) begin
            nxt_pf = 1'b0;
            if (pf || wr_hit)
                nxt_act = src_div;
        end

        nxt_cnt  = boundary ? '0 : cnt + CNT_W'(1);
        nxt_clk  = (nxt_cnt >= nxt_act - (nxt_act >> 1));
        nxt_tick = en && !restart && wrap;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            act     <= INIT_C;
            pend    <= INIT_C;
            pf      <= 1'b0;
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            act     <= nxt_act;
            pend    <= nxt_pend;
            pf      <= nxt_pf;
            cnt     <= nxt_cnt;
            clk_out <= nxt_clk;
            tick    <= nxt_tick;
        end
    end
endmodule

module multi_clock_divider #(
    parameter int                      NUM_CH   = 2,
    parameter int                      CNT_W    = 32,
    parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {32'd100000000, 32'd10000000},
    localparam int                     CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] en,
    input  logic [NUM_CH-1:0] restart,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_div,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);
    // Out-of-range wr_ch matches no channel, so such writes fall away naturally.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wr_hit;
        assign wr_hit = wr_en && (wr_ch == CH_W'(i));

        multi_clock_divider_ch #(
            .CNT_W (CNT_W),
            .INIT  (DIV_INIT[i*CNT_W +: CNT_W])
        ) u_ch (
            .clock   (clock),
            .reset   (reset),
            .en      (en[i]),
            .restart (restart[i]),
            .wr_hit  (wr_hit),
            .wr_div  (wr_div),
            .clk_out (clk_out[i]),
            .tick    (tick[i])
        );
    end
endmodule

// File: tb/tb_multi_clock_divider.sv
// Bench for multi_clock_divider: directed scenarios plus random traffic, all
// checked against a period-position model of each channel.

module tb_multi_clock_divider;
    localparam int NUM_CH = 3;
    localparam int CNT_W  = 32;
    localparam logic [NUM_CH*CNT_W-1:0] DIV_INIT = {32'd7, 32'd10, 32'd4};

    logic              clock, reset;
    logic [NUM_CH-1:0] en, restart;
    logic              wr_en;
    logic [1:0]        wr_ch;
    logic [CNT_W-1:0]  wr_div;
    logic [NUM_CH-1:0] clk_out, tick;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: period length, queued length, position within the period.
    int unsigned       m_act [NUM_CH];
    int unsigned       m_pend[NUM_CH];
    int unsigned       m_pos [NUM_CH];
    bit                m_pf  [NUM_CH];
    logic [NUM_CH-1:0] m_clk, m_tick;

    multi_clock_divider #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DIV_INIT(DIV_INIT)) dut (
        .clock(clock), .reset(reset), .en(en), .restart(restart),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div),
        .clk_out(clk_out), .tick(tick)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int unsigned clamp2(int unsigned d);
        return (d < 2) ? 2 : d;
    endfunction

    task automatic step();
        @(posedge clock);
        cyc++;
        for (int i = 0; i < NUM_CH; i++) begin
            if (reset) begin
                m_act[i]  = clamp2(DIV_INIT[i*CNT_W +: CNT_W]);
                m_pend[i] = m_act[i];
                m_pf[i]   = 0;
                m_pos[i]  = 0;
                m_clk[i]  = 0;
                m_tick[i] = 0;
            end else begin
                bit end_of_period;
                end_of_period = (m_pos[i] + 1 == m_act[i]);
                if (wr_en && wr_ch == i) begin
                    m_pend[i] = clamp2(wr_div);
                    m_pf[i]   = 1;
                end
                m_tick[i] = en[i] && !restart[i] && end_of_period;
                if (restart[i] || !en[i]) m_pos[i] = 0;
                else m_pos[i] = (m_pos[i] + 1) % m_act[i];
                if ((restart[i] || !en[i] || end_of_period) && m_pf[i]) begin
                    m_act[i] = m_pend[i];
                    m_pf[i]  = 0;
                end
                m_clk[i] = (m_pos[i] >= m_act[i] - m_act[i] / 2);
            end
        end
        #1;
    endtask

    task automatic write_div(int ch, int unsigned d);
        wr_en = 1; wr_ch = 2'(ch); wr_div = d;
        step();
        wr_en = 0;
    endtask

    task automatic test_reset();
        reset = 1; en = '1; restart = '0; wr_en = 0; wr_ch = 0; wr_div = 0;
        step(); step();
        checks++;
        if (clk_out !== '0 || tick !== '0) begin
            errors++; $display("FAIL reset_outputs clk_out=%b tick=%b want 000/000", clk_out, tick);
        end
        reset = 0;
    endtask

    task automatic test_basic();
        en = '1;
        for (int k = 1; k <= 40; k++) begin
            step();
            checks++;
            if (clk_out[0] !== ((k % 4) >= 2)) begin
                errors++; $display("FAIL basic_ch0_pattern k=%0d got=%b want=%b", k, clk_out[0], (k % 4) >= 2);
            end
            checks++;
            if (clk_out !== m_clk || tick !== m_tick) begin
                errors++; $display("FAIL basic_model k=%0d got=%b/%b want=%b/%b", k, clk_out, tick, m_clk, m_tick);
            end
        end
    endtask

    task automatic test_write_mid();
        int n, gap;
        n = 0;
        while (tick[0] !== 1'b1 && n < 20) begin step(); n++; end
        checks++;
        if (tick[0] !== 1'b1) begin errors++; $display("FAIL write_mid_align got=%b want=1", tick[0]); end
        step();
        write_div(0, 8);
        gap = 2;
        for (int g = 0; g < 3; g++) begin
            n = 0;
            do begin step(); gap++; n++; end while (tick[0] !== 1'b1 && n < 20);
            checks++;
            if (gap !== ((g == 0) ? 4 : 8)) begin
                errors++; $display("FAIL write_mid_gap%0d got=%0d want=%0d", g, gap, (g == 0) ? 4 : 8);
            end
            gap = 0;
        end
    endtask

    task automatic test_write_wrap();
        int n, gap;
        en[0] = 0;
        write_div(0, 4);
        en[0] = 1;
        step(); step(); step();
        wr_en = 1; wr_ch = 0; wr_div = 6;
        step();
        wr_en = 0;
        checks++;
        if (tick[0] !== 1'b1) begin errors++; $display("FAIL write_wrap_tick got=%b want=1", tick[0]); end
        gap = 0; n = 0;
        do begin step(); gap++; n++; end while (tick[0] !== 1'b1 && n < 20);
        checks++;
        if (gap !== 6) begin errors++; $display("FAIL write_wrap_gap got=%0d want=6", gap); end
    endtask

    task automatic test_odd();
        int last, seen;
        en[0] = 0;
        write_div(0, 5);
        en[0] = 1;
        last = cyc; seen = 0;
        for (int k = 0; k < 22; k++) begin
            step();
            checks++;
            if (clk_out !== m_clk || tick !== m_tick) begin
                errors++; $display("FAIL odd_model k=%0d got=%b/%b want=%b/%b", k, clk_out, tick, m_clk, m_tick);
            end
            if (tick[0] === 1'b1) begin
                checks++;
                if (cyc - last !== 5) begin errors++; $display("FAIL odd_gap got=%0d want=5", cyc - last); end
                last = cyc; seen++;
            end
        end
        checks++;
        if (seen !== 4) begin errors++; $display("FAIL odd_tick_count got=%0d want=4", seen); end
    endtask

    task automatic test_clamp();
        logic prev;
        write_div(0, 0);
        write_div(1, 1);
        restart = 3'b011;
        step();
        restart = '0;
        prev = clk_out[0];
        for (int k = 0; k < 12; k++) begin
            step();
            checks++;
            if (clk_out[0] === prev) begin errors++; $display("FAIL clamp_toggle k=%0d got=%b want=%b", k, clk_out[0], ~prev); end
            prev = clk_out[0];
            checks++;
            if (clk_out !== m_clk || tick !== m_tick) begin
                errors++; $display("FAIL clamp_model k=%0d got=%b/%b want=%b/%b", k, clk_out, tick, m_clk, m_tick);
            end
        end
    endtask

    task automatic test_bad_ch();
        write_div(3, 9);
        for (int k = 0; k < 30; k++) begin
            step();
            checks++;
            if (clk_out !== m_clk || tick !== m_tick) begin
                errors++; $display("FAIL bad_ch_model k=%0d got=%b/%b want=%b/%b", k, clk_out, tick, m_clk, m_tick);
            end
        end
    endtask

    task automatic test_restart();
        write_div(1, 10);
        en = '1;
        for (int k = 0; k < 13; k++) step();
        restart = 3'b010;
        step();
        restart = '0;
        checks++;
        if (clk_out[1] !== 1'b0 || tick[1] !== 1'b0) begin
            errors++; $display("FAIL restart_outputs got=%b/%b want=0/0", clk_out[1], tick[1]);
        end
        for (int k = 1; k <= 25; k++) begin
            step();
            checks++;
            if (tick[1] !== (k == 10 || k == 20)) begin
                errors++; $display("FAIL restart_tick k=%0d got=%b want=%b", k, tick[1], (k == 10 || k == 20));
            end
            checks++;
            if (clk_out !== m_clk || tick !== m_tick) begin
                errors++; $display("FAIL restart_model k=%0d got=%b/%b want=%b/%b", k, clk_out, tick, m_clk, m_tick);
            end
        end
    endtask

    task automatic test_reset_mid();
        en = '1;
        step(); step();
        write_div(0, 8);
        reset = 1;
        step();
        checks++;
        if (clk_out !== '0 || tick !== '0) begin
            errors++; $display("FAIL reset_mid_outputs got=%b/%b want=000/000", clk_out, tick);
        end
        reset = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            checks++;
            if (tick[0] !== (k % 4 == 0)) begin
                errors++; $display("FAIL reset_mid_ch0_tick k=%0d got=%b want=%b", k, tick[0], (k % 4 == 0));
            end
            checks++;
            if (clk_out !== m_clk || tick !== m_tick) begin
                errors++; $display("FAIL reset_mid_model k=%0d got=%b/%b want=%b/%b", k, clk_out, tick, m_clk, m_tick);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                en[i]      = ($urandom_range(0, 9) != 0);
                restart[i] = ($urandom_range(0, 29) == 0);
            end
            wr_en  = ($urandom_range(0, 3) == 0);
            wr_ch  = 2'($urandom_range(0, 3));
            wr_div = $urandom_range(0, 12);
            step();
            checks++;
            if (clk_out !== m_clk || tick !== m_tick) begin
                errors++; $display("FAIL random_model k=%0d got=%b/%b want=%b/%b", k, clk_out, tick, m_clk, m_tick);
            end
        end
        wr_en = 0; restart = '0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_write_mid();
        test_write_wrap();
        test_odd();
        test_clamp();
        test_bad_ch();
        test_restart();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
